// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin pick of four valid/ready sources into a one-entry
// output register that also drives the select pair for the downstream 2:1 mux tree.
module mux4_rr_arbiter #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             sel_lo,
  output logic             sel_hi,
  output logic [CNT_W-1:0] xfer_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_next;
  logic [1:0] last_grant, grant, idx;
  logic found, free, accept;
  logic [WIDTH-1:0] grant_data;
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    free = (state == EMPTY) || out_ready;
    accept = free && found;
    state_next = accept ? FULL : (state == FULL && out_ready) ? EMPTY : state;
    in_ready = (accept && rst_n) ? 4'b0001 << grant : 4'b0000;
    grant_data = grant[1] ? (grant[0] ? in_d : in_c) : (grant[0] ? in_b : in_a);
  end
  assign out_valid = (state == FULL);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_next;
  // Pointer starts at 3 so source 0 wins the first arbitration after reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant <= 2'd3;
      out_data <= '0;
      out_src <= 2'd0;
      sel_lo <= 1'b0;
      sel_hi <= 1'b0;
      xfer_cnt <= '0;
    end else if (accept) begin
      last_grant <= grant;
      out_data <= grant_data;
      out_src <= grant;
      sel_lo <= grant[0];
      sel_hi <= grant[1];
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: vector table plus scoreboard of granted data against the
// registered output; a hand-written sequence covers reset in the middle of a stall.
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] in_valid, in_ready;
  logic in_a, in_b, in_c, in_d;
  logic out_valid, out_ready, out_data, sel_lo, sel_hi;
  logic [1:0] out_src;
  logic [3:0] xfer_cnt;
  int checks = 0, failures = 0;
  typedef struct {logic [3:0] v; logic r; logic [3:0] d; logic [3:0] er;} vec_t;
  typedef struct {logic [1:0] src; logic data;} exp_t;
  vec_t tbl[$];
  exp_t q[$];
  logic [3:0] cnt;

  mux4_rr_arbiter #(.WIDTH(1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .sel_lo(sel_lo), .sel_hi(sel_hi), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    return oh[1] ? 2'd1 : oh[2] ? 2'd2 : oh[3] ? 2'd3 : 2'd0;
  endfunction

  function automatic void add(input logic [3:0] v, input logic r, input logic [3:0] d,
                              input logic [3:0] er, input int n);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.er = er;
    for (int i = 0; i < n; i++) tbl.push_back(t);
  endfunction

  task automatic step(input logic [3:0] v, input logic r, input logic [3:0] d, input logic [3:0] er);
    exp_t e;
    in_valid = v;
    out_ready = r;
    {in_d, in_c, in_b, in_a} = d;
    #1;
    chk("in_ready", 16'(in_ready), 16'(er));
    chk("out_valid", 16'(out_valid), 16'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      chk("out_src", 16'(out_src), 16'(e.src));
      chk("out_data", 16'(out_data), 16'(e.data));
      chk("sel_hi", 16'(sel_hi), 16'(e.src[1]));
      chk("sel_lo", 16'(sel_lo), 16'(e.src[0]));
      if (r) void'(q.pop_front());
    end
    chk("xfer_cnt", 16'(xfer_cnt), 16'(cnt));
    if (er != 4'b0000) begin
      e.src = idx_of(er);
      e.data = d[idx_of(er)];
      q.push_back(e);
      cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    add(4'b1111, 1, 4'b1010, 4'b0001, 1);
    add(4'b1111, 1, 4'b1010, 4'b0010, 1);
    add(4'b1111, 1, 4'b1010, 4'b0100, 1);
    add(4'b1111, 1, 4'b1010, 4'b1000, 1);
    add(4'b1111, 1, 4'b1010, 4'b0001, 1);
    add(4'b1101, 1, 4'b1010, 4'b0100, 1);
    add(4'b1101, 1, 4'b1010, 4'b1000, 1);
    add(4'b1111, 1, 4'b1010, 4'b0001, 1);
    add(4'b0100, 1, 4'b0100, 4'b0100, 3);
    add(4'b0010, 1, 4'b0010, 4'b0010, 1);
    add(4'b1111, 0, 4'b1010, 4'b0000, 3);
    add(4'b1111, 1, 4'b0100, 4'b0100, 1);
    add(4'b0001, 1, 4'b0001, 4'b0001, 1);
    add(4'b1001, 1, 4'b1000, 4'b1000, 1);
    add(4'b1001, 1, 4'b0001, 4'b0001, 1);
    add(4'b0000, 1, 4'b0000, 4'b0000, 2);
    add(4'b0010, 0, 4'b0010, 4'b0010, 1);
    add(4'b0001, 0, 4'b1111, 4'b0000, 1);
    add(4'b0001, 1, 4'b1110, 4'b0001, 1);
    add(4'b1111, 1, 4'b1010, 4'b0010, 1);
    add(4'b1111, 0, 4'b1010, 4'b0000, 1);

    rst_n = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    {in_d, in_c, in_b, in_a} = 4'b1111;
    cnt = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst in_ready", 16'(in_ready), 16'h0);
    chk("rst out_valid", 16'(out_valid), 16'h0);
    chk("rst out_data", 16'(out_data), 16'h0);
    chk("rst out_src", 16'(out_src), 16'h0);
    chk("rst sel", 16'({sel_hi, sel_lo}), 16'h0);
    chk("rst xfer_cnt", 16'(xfer_cnt), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].er);

    in_valid = 4'b1111;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async out_valid", 16'(out_valid), 16'h0);
    chk("async in_ready", 16'(in_ready), 16'h0);
    chk("async xfer_cnt", 16'(xfer_cnt), 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    cnt = '0;
    step(4'b1111, 1, 4'b1010, 4'b0001);
    step(4'b1111, 1, 4'b1010, 4'b0010);
    step(4'b0000, 1, 4'b0000, 4'b0000);
    step(4'b0000, 1, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
